// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array front-end feeder:
// FSM state encoding and counter sizing helper.
package systolic_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WCOLLECT = 3'd1,
        WPUSH    = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4
    } feeder_state_t;

    // Counters need one extra bit beyond the index width.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// Per-row delay line (data plus valid tag) used to skew features into
// the left column; STAGES=0 degenerates to a wire.
module skew_line
    import systolic_feeder_pkg::*;
#(
    parameter int bit_width = 8,
    parameter int STAGES    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [bit_width-1:0] shift_data,
    input  logic                 shift_valid,
    output logic [bit_width-1:0] line_data,
    output logic                 line_valid
);

    generate
        if (STAGES == 0) begin : g_pass
            logic unused_clk_rst_s;
            assign unused_clk_rst_s = clk ^ reset;
            assign line_data        = shift_data;
            assign line_valid       = shift_valid;
        end else begin : g_shift
            logic [bit_width-1:0] data_r [STAGES];
            logic [STAGES-1:0]    valid_r;

            // Shift data and valid one stage per cycle, cleared by reset
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < STAGES; k++) begin
                        data_r[k] <= {bit_width{1'b0}};
                    end
                    valid_r <= {STAGES{1'b0}};
                end else begin
                    data_r[0]  <= shift_data;
                    valid_r[0] <= shift_valid;
                    for (int k = 1; k < STAGES; k++) begin
                        data_r[k]  <= data_r[k-1];
                        valid_r[k] <= valid_r[k-1];
                    end
                end
            end

            assign line_data  = data_r[STAGES-1];
            assign line_valid = valid_r[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Front end of the weight-stationary MAC array: collects a weight tile,
// shifts it in from the top, then streams skewed features and drains.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int bit_width    = 8,
    parameter int depth        = 4,
    parameter int DRAIN_CYCLES = 2 * depth
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [depth*bit_width-1:0] w_row,
    input  logic                       f_valid,
    output logic                       f_ready,
    input  logic [depth*bit_width-1:0] f_vec,
    input  logic                       f_last,
    output logic                       arr_control,
    output logic [depth*bit_width-1:0] arr_weight,
    output logic [depth*bit_width-1:0] arr_data,
    output logic [depth-1:0]           arr_valid,
    output logic                       busy,
    output logic                       tile_done
);

    localparam int CW = cnt_width(depth);
    localparam int DW = cnt_width(DRAIN_CYCLES);
    localparam int IW = (depth > 1) ? $clog2(depth) : 1;
    localparam int VW = depth * bit_width;

    localparam logic [CW-1:0] LAST_ROW   = CW'(depth - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_CYCLES - 1);

    feeder_state_t   state_r;
    logic [CW-1:0]   wcnt_r;
    logic [CW-1:0]   pcnt_r;
    logic [DW-1:0]   dcnt_r;
    logic [VW-1:0]   weight_buf_r [depth];
    logic            arr_control_r;
    logic [VW-1:0]   arr_weight_r;
    logic            busy_r;
    logic            tile_done_r;
    logic [VW-1:0]   head_data_r;
    logic [depth-1:0] head_valid_r;

    logic            w_accept_s;
    logic            f_accept_s;
    logic [IW-1:0]   push_idx_s;

    assign w_ready    = reset && ((state_r == IDLE) || (state_r == WCOLLECT));
    assign f_ready    = reset && (state_r == STREAM);
    assign w_accept_s = w_valid && w_ready;
    assign f_accept_s = f_valid && f_ready;

    // Bottom row goes in first so that after depth shifts row r holds buffer[r]
    always_comb begin
        push_idx_s = IW'(LAST_ROW - pcnt_r);
    end

    // Tile sequencing FSM with its registered array-control outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            wcnt_r        <= {CW{1'b0}};
            pcnt_r        <= {CW{1'b0}};
            dcnt_r        <= {DW{1'b0}};
            for (int r = 0; r < depth; r++) begin
                weight_buf_r[r] <= {VW{1'b0}};
            end
            arr_control_r <= 1'b0;
            arr_weight_r  <= {VW{1'b0}};
            busy_r        <= 1'b0;
            tile_done_r   <= 1'b0;
        end else begin
            arr_control_r <= 1'b0;
            arr_weight_r  <= {VW{1'b0}};
            tile_done_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (w_accept_s) begin
                        weight_buf_r[0] <= w_row;
                        wcnt_r          <= CW'(1);
                        pcnt_r          <= {CW{1'b0}};
                        busy_r          <= 1'b1;
                        state_r         <= (depth == 1) ? WPUSH : WCOLLECT;
                    end
                end
                WCOLLECT: begin
                    if (w_accept_s) begin
                        weight_buf_r[wcnt_r[IW-1:0]] <= w_row;
                        if (wcnt_r == LAST_ROW) begin
                            wcnt_r  <= {CW{1'b0}};
                            pcnt_r  <= {CW{1'b0}};
                            state_r <= WPUSH;
                        end else begin
                            wcnt_r <= wcnt_r + CW'(1);
                        end
                    end
                end
                WPUSH: begin
                    arr_control_r <= 1'b1;
                    arr_weight_r  <= weight_buf_r[push_idx_s];
                    if (pcnt_r == LAST_ROW) begin
                        pcnt_r  <= {CW{1'b0}};
                        state_r <= STREAM;
                    end else begin
                        pcnt_r <= pcnt_r + CW'(1);
                    end
                end
                STREAM: begin
                    if (f_accept_s && f_last) begin
                        dcnt_r  <= {DW{1'b0}};
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dcnt_r == LAST_DRAIN) begin
                        dcnt_r      <= {DW{1'b0}};
                        tile_done_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        dcnt_r <= dcnt_r + DW'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Chain heads: accepted vector or a zero bubble every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_data_r  <= {VW{1'b0}};
            head_valid_r <= {depth{1'b0}};
        end else begin
            head_data_r  <= f_accept_s ? f_vec : {VW{1'b0}};
            head_valid_r <= {depth{f_accept_s}};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < depth; gi++) begin : g_row
            skew_line #(
                .bit_width (bit_width),
                .STAGES    (gi)
            ) u_skew (
                .clk         (clk),
                .reset       (reset),
                .shift_data  (head_data_r[gi*bit_width +: bit_width]),
                .shift_valid (head_valid_r[gi]),
                .line_data   (arr_data[gi*bit_width +: bit_width]),
                .line_valid  (arr_valid[gi])
            );
        end
    endgenerate

    assign arr_control = arr_control_r;
    assign arr_weight  = arr_weight_r;
    assign busy        = busy_r;
    assign tile_done   = tile_done_r;

endmodule
